// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two valid/ready requesters.
// Optional `ALU_ARB_STATS_EN adds saturating grant and illegal-opcode counters.
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ARB_MODE      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_x0,
  input  logic [31:0] req_x1,
  input  logic [31:0] req_y0,
  input  logic [31:0] req_y1,
  input  logic [5:0]  req_ctrl0,
  input  logic [5:0]  req_ctrl1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic        alu_nx,
  output logic        alu_ix,
  output logic        alu_sx,
  output logic        alu_ny,
  output logic        alu_iy,
  output logic        alu_sy,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [7:0]  err_cnt,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic [3:0]  op_q, op_d;
  logic        win, accept, illegal;
  logic [3:0]  sel_op;
  always_comb begin
    win       = (&req_valid) ? ((ARB_MODE == 1) ? 1'b0 : ~last_grant_q) : req_valid[1];
    // rst_n gates the handshake so nothing is offered while reset is held
    accept    = rst_n & (state_q == IDLE) & (|req_valid);
    req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
    sel_op    = win ? req_op1 : req_op0;
    illegal   = sel_op >= 4'd14;
  end
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    x_d          = x_q;
    y_d          = y_q;
    ctrl_d       = ctrl_q;
    op_d         = op_q;
    if (accept) begin
      x_d          = win ? req_x1 : req_x0;
      y_d          = win ? req_y1 : req_y0;
      ctrl_d       = win ? req_ctrl1 : req_ctrl0;
      op_d         = sel_op;
      grant_id_d   = win;
      last_grant_d = win;
      cnt_d        = SETTLE_LOAD;
      state_d      = illegal ? RESP : EXEC;
      rsp_valid_d  = illegal ? (win ? 2'b10 : 2'b01) : 2'b00;
      rsp_err_d    = illegal;
      rsp_data_d   = illegal ? 32'd0 : rsp_data_q;
      rsp_zero_d   = illegal ? 1'b0 : rsp_zero_q;
    end else if (state_q == EXEC) begin
      cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        rsp_data_d  = alu_out;
        rsp_zero_d  = alu_zero;
        rsp_err_d   = 1'b0;
        rsp_valid_d = grant_id_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
    end else if (state_q == RESP && rsp_ready[grant_id_q]) begin
      rsp_valid_d = 2'b00;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      x_q          <= 32'd0;
      y_q          <= 32'd0;
      ctrl_q       <= 6'd0;
      op_q         <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ctrl_q       <= ctrl_d;
      op_q         <= op_d;
    end
  end
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign {alu_nx, alu_ix, alu_sx, alu_ny, alu_iy, alu_sy} = ctrl_q;
  assign alu_opcode = op_q;
  assign busy       = state_q != IDLE;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d, grant_cnt1_q, grant_cnt1_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  always_comb begin
    grant_cnt0_d = (accept && !win && grant_cnt0_q != 16'hFFFF) ? grant_cnt0_q + 16'd1 : grant_cnt0_q;
    grant_cnt1_d = (accept && win && grant_cnt1_q != 16'hFFFF) ? grant_cnt1_q + 16'd1 : grant_cnt1_q;
    err_cnt_d    = (accept && illegal && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      err_cnt_q    <= err_cnt_d;
    end
  end
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign err_cnt    = err_cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two instances (SETTLE=1/round-robin, SETTLE=4/fixed priority)
// checked against a transaction-level model of grants, latency and results.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid[2], req_ready[2], rsp_valid[2], rsp_ready[2];
  logic [31:0] req_x0[2], req_x1[2], req_y0[2], req_y1[2];
  logic [5:0]  req_ctrl0[2], req_ctrl1[2];
  logic [3:0]  req_op0[2], req_op1[2], alu_opcode[2];
  logic [31:0] rsp_data[2], alu_x[2], alu_y[2], alu_out[2];
  logic        rsp_zero[2], rsp_err[2], alu_zero[2], busy[2];
  logic        alu_nx[2], alu_ix[2], alu_sx[2], alu_ny[2], alu_iy[2], alu_sy[2];
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0[2], grant_cnt1[2];
  logic [7:0]  err_cnt[2];
`endif
  int errors = 0;
  int checks = 0;
  int last_m[2];
  int gc0_m[2], gc1_m[2], ec_m[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    return (op == 4'd0) ? x + y : (op == 4'd1) ? x - y : x ^ {y[15:0], y[31:16]};
  endfunction

  function automatic int settle(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.SETTLE_CYCLES(g == 0 ? 1 : 4), .ARB_MODE(g == 0 ? 0 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_x0(req_x0[g]), .req_x1(req_x1[g]), .req_y0(req_y0[g]), .req_y1(req_y1[g]),
      .req_ctrl0(req_ctrl0[g]), .req_ctrl1(req_ctrl1[g]), .req_op0(req_op0[g]), .req_op1(req_op1[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_zero(rsp_zero[g]), .rsp_err(rsp_err[g]),
      .alu_x(alu_x[g]), .alu_y(alu_y[g]),
      .alu_nx(alu_nx[g]), .alu_ix(alu_ix[g]), .alu_sx(alu_sx[g]),
      .alu_ny(alu_ny[g]), .alu_iy(alu_iy[g]), .alu_sy(alu_sy[g]),
      .alu_opcode(alu_opcode[g]), .alu_out(alu_out[g]), .alu_zero(alu_zero[g]),
`ifdef ALU_ARB_STATS_EN
      .grant_cnt0(grant_cnt0[g]), .grant_cnt1(grant_cnt1[g]), .err_cnt(err_cnt[g]),
`endif
      .busy(busy[g])
    );
    assign alu_out[g]  = alu_fn(alu_x[g], alu_y[g], alu_opcode[g]);
    assign alu_zero[g] = alu_out[g] == 32'd0;
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_m[d] = 1;
      gc0_m[d] = 0;
      gc1_m[d] = 0;
      ec_m[d] = 0;
    end
  endtask

  // One complete request/response; bp = back-pressure cycles in RESP.
  task automatic txn(input int d, input logic [1:0] v, input logic [31:0] x0, input logic [31:0] y0,
                     input logic [3:0] op0, input logic [31:0] x1, input logic [31:0] y1,
                     input logic [3:0] op1, input int bp, output int w);
    logic [31:0] ex, ey, ed;
    logic [5:0]  c0, c1, ec;
    logic [3:0]  eo;
    logic        ee;
    logic [1:0]  oh;
    int          lat, el;
    c0 = 6'($urandom);
    c1 = 6'($urandom);
    w  = (v == 2'b11) ? ((d == 1) ? 0 : 1 - last_m[d]) : (v[1] ? 1 : 0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    ex = (w == 1) ? x1 : x0;
    ey = (w == 1) ? y1 : y0;
    ec = (w == 1) ? c1 : c0;
    eo = (w == 1) ? op1 : op0;
    ee = eo >= 4'd14;
    ed = ee ? 32'd0 : alu_fn(ex, ey, eo);
    el = ee ? 1 : settle(d) + 1;
    @(negedge clk);
    req_x0[d] = x0; req_y0[d] = y0; req_ctrl0[d] = c0; req_op0[d] = op0;
    req_x1[d] = x1; req_y1[d] = y1; req_ctrl1[d] = c1; req_op1[d] = op1;
    req_valid[d] = v;
    rsp_ready[d] = (bp > 0) ? ~oh : oh;
    #1;
    checks++;
    if (req_ready[d] !== oh) begin
      errors++;
      $display("FAIL grant[%0d]: req_ready=%b expected %b", d, req_ready[d], oh);
    end
    @(posedge clk);
    last_m[d] = w;
    if (w == 0) gc0_m[d]++; else gc1_m[d]++;
    if (ee) ec_m[d]++;
    #1;
    req_valid[d] = 2'b00;
    lat = 1;
    while (rsp_valid[d] === 2'b00 && lat < 40) begin
      checks++;
      if ({alu_x[d], alu_y[d], alu_nx[d], alu_ix[d], alu_sx[d], alu_ny[d], alu_iy[d], alu_sy[d], alu_opcode[d]}
          !== {ex, ey, ec, eo}) begin
        errors++;
        $display("FAIL alu_hold[%0d]: x=%h y=%h op=%0d expected x=%h y=%h op=%0d",
                 d, alu_x[d], alu_y[d], alu_opcode[d], ex, ey, eo);
      end
      checks++;
      if ({req_ready[d], busy[d]} !== 3'b001) begin
        errors++;
        $display("FAIL exec_flags[%0d]: req_ready=%b busy=%b expected 00/1", d, req_ready[d], busy[d]);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != el) begin
      errors++;
      $display("FAIL latency[%0d]: %0d cycles expected %0d", d, lat, el);
    end
    checks++;
    if (rsp_valid[d] !== oh) begin
      errors++;
      $display("FAIL rsp_valid[%0d]: %b expected %b", d, rsp_valid[d], oh);
    end
    checks++;
    if ({rsp_data[d], rsp_zero[d], rsp_err[d]} !== {ed, ed == 32'd0 && !ee, ee}) begin
      errors++;
      $display("FAIL rsp[%0d]: data=%h zero=%b err=%b expected data=%h zero=%b err=%b",
               d, rsp_data[d], rsp_zero[d], rsp_err[d], ed, ed == 32'd0 && !ee, ee);
    end
    checks++;
    if (alu_opcode[d] !== eo) begin
      errors++;
      $display("FAIL opcode_latch[%0d]: %0d expected %0d", d, alu_opcode[d], eo);
    end
    for (int i = 0; i < bp; i++) begin
      req_valid[d] = 2'b11;
      @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid[d], rsp_data[d], rsp_err[d], req_ready[d]} !== {oh, ed, ee, 2'b00}) begin
        errors++;
        $display("FAIL backpressure[%0d]: rsp_valid=%b data=%h req_ready=%b expected %b %h 00",
                 d, rsp_valid[d], rsp_data[d], req_ready[d], oh, ed);
      end
    end
    req_valid[d] = 2'b00;
    rsp_ready[d] = oh;
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid[d], busy[d]} !== 3'b000) begin
      errors++;
      $display("FAIL release[%0d]: rsp_valid=%b busy=%b expected 00/0", d, rsp_valid[d], busy[d]);
    end
    rsp_ready[d] = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 2'b11; rsp_ready[d] = 2'b00;
      req_x0[d] = '0; req_x1[d] = '0; req_y0[d] = '0; req_y1[d] = '0;
      req_ctrl0[d] = '0; req_ctrl1[d] = '0; req_op0[d] = '0; req_op1[d] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({req_ready[d], rsp_valid[d], rsp_data[d], rsp_zero[d], rsp_err[d], alu_x[d], alu_y[d],
           alu_nx[d], alu_ix[d], alu_sx[d], alu_ny[d], alu_iy[d], alu_sy[d], alu_opcode[d], busy[d]} !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: req_ready=%b rsp_valid=%b data=%h x=%h op=%0d busy=%b expected all 0",
                 d, req_ready[d], rsp_valid[d], rsp_data[d], alu_x[d], alu_opcode[d], busy[d]);
      end
      req_valid[d] = 2'b00;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    int w;
    txn(0, 2'b01, 32'd5, 32'd7, 4'd0, $urandom, $urandom, 4'd0, 0, w);
  endtask

  task automatic test_round_robin();
    int w, prev;
    txn(0, 2'b11, $urandom, $urandom, 4'($urandom_range(0, 13)), $urandom, $urandom, 4'($urandom_range(0, 13)), 0, prev);
    for (int i = 0; i < 3; i++) begin
      txn(0, 2'b11, $urandom, $urandom, 4'($urandom_range(0, 13)), $urandom, $urandom, 4'($urandom_range(0, 13)), 0, w);
      prev = w;
    end
  endtask

  task automatic test_fixed_priority();
    int w;
    for (int i = 0; i < 3; i++)
      txn(1, 2'b11, $urandom, $urandom, 4'($urandom_range(0, 13)), $urandom, $urandom, 4'($urandom_range(0, 13)), 0, w);
  endtask

  task automatic test_illegal();
    int w;
    txn(0, 2'b10, $urandom, $urandom, 4'd0, $urandom, $urandom, 4'd15, 0, w);
    txn(0, 2'b01, $urandom, $urandom, 4'd14, $urandom, $urandom, 4'd0, 0, w);
    txn(1, 2'b10, $urandom, $urandom, 4'd0, $urandom, $urandom, 4'd15, 2, w);
  endtask

  task automatic test_backpressure();
    int w;
    txn(0, 2'b01, $urandom, $urandom, 4'd1, $urandom, $urandom, 4'd0, 10, w);
  endtask

  task automatic test_settle4();
    int w;
    txn(1, 2'b10, $urandom, $urandom, 4'd0, 32'd3, 32'd3, 4'd1, 0, w);
  endtask

  task automatic test_back_to_back();
    int g;
    logic [1:0] exp;
    g = 1 - last_m[0];
    @(negedge clk);
    req_op0[0] = 4'd0; req_op1[0] = 4'd0;
    req_valid[0] = 2'b11;
    rsp_ready[0] = 2'b11;
    #1;
    for (int i = 0; i < 12; i++) begin
      exp = (i % 3 == 0) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (req_ready[0] !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: req_ready=%b expected %b", i, req_ready[0], exp);
      end
      if (i % 3 == 0) begin
        last_m[0] = g;
        if (g == 0) gc0_m[0]++; else gc1_m[0]++;
        g = 1 - g;
      end
      @(negedge clk);
      #1;
    end
    req_valid[0] = 2'b00;
    rsp_ready[0] = 2'b00;
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 24; i++)
      txn($urandom_range(0, 1), 2'($urandom_range(1, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)),
          $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), w);
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk);
    req_x0[0] = $urandom; req_y0[0] = $urandom; req_op0[0] = 4'd0;
    req_valid[0] = 2'b01;
    @(posedge clk);
    #1;
    req_valid[0] = 2'b11;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec_busy: busy=%b expected 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid[0], req_ready[0], busy[0]} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: rsp_valid=%b req_ready=%b busy=%b expected 0", rsp_valid[0], req_ready[0], busy[0]);
    end
    @(negedge clk);
    req_valid[0] = 2'b00;
    model_reset();
    rst_n = 1'b1;
    txn(0, 2'b11, $urandom, $urandom, 4'd2, $urandom, $urandom, 4'd2, 0, w);
  endtask

  task automatic test_stats();
`ifdef ALU_ARB_STATS_EN
    txn_stats_extra();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({grant_cnt0[d], grant_cnt1[d], err_cnt[d]} !== {16'(gc0_m[d]), 16'(gc1_m[d]), 8'(ec_m[d])}) begin
        errors++;
        $display("FAIL stats[%0d]: g0=%0d g1=%0d err=%0d expected %0d %0d %0d",
                 d, grant_cnt0[d], grant_cnt1[d], err_cnt[d], gc0_m[d], gc1_m[d], ec_m[d]);
      end
    end
`endif
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic txn_stats_extra();
    int w;
    int before;
    before = gc1_m[1];
    txn(1, 2'b10, $urandom, $urandom, 4'd0, 32'd3, 32'd3, 4'd1, 0, w);
    checks++;
    if (grant_cnt1[1] !== 16'(before + 1)) begin
      errors++;
      $display("FAIL stats_incr: grant_cnt1=%0d expected %0d", grant_cnt1[1], before + 1);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_fixed_priority();
    test_illegal();
    test_backpressure();
    test_settle4();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
